// File: rtl/adbg_cpu_dbg_responder.sv
// adbg_cpu_dbg_responder: core-side debug responder (CTRL/REASON, halt, GPR/NPC forwarding); ADBG_CPU_RSP_HWBP_EN adds a PC breakpoint
module adbg_cpu_dbg_responder #(
    parameter int CPU_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_STATES    = 1
) (
    input  logic                      cpu_clk_i,
    input  logic                      rst_i,
    input  logic [CPU_ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]     dbg_data_i,
    output logic [DATA_WIDTH-1:0]     dbg_data_o,
    input  logic                      dbg_stb_i,
    input  logic                      dbg_we_i,
    output logic                      dbg_ack_o,
    input  logic                      dbg_stall_i,
    output logic                      dbg_bp_o,
    output logic                      core_halt_o,
    input  logic                      core_trap_i,
    input  logic                      core_retire_i,
    input  logic [DATA_WIDTH-1:0]     core_npc_i,
    output logic [DATA_WIDTH-1:0]     core_npc_o,
    output logic                      core_npc_we_o,
    output logic [4:0]                core_gpr_addr_o,
    output logic                      core_gpr_re_o,
    input  logic [DATA_WIDTH-1:0]     core_gpr_rdata_i,
    output logic                      core_gpr_we_o,
`ifdef ADBG_CPU_RSP_HWBP_EN
    input  logic [DATA_WIDTH-1:0]     core_pc_i,
    input  logic                      core_fetch_i,
`endif
    output logic [DATA_WIDTH-1:0]     core_gpr_wdata_o
);
`ifdef ADBG_CPU_RSP_HWBP_EN
    localparam int RW = 3;
`else
    localparam int RW = 2;
`endif
    typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;
    state_t state;
    logic [CPU_ADDR_WIDTH-1:0] a_q;
    logic we_q, h_q, go, in_gpr, in_npc, wr, step, trap;
    logic [3:0] cnt;
    logic [RW-1:0] ctrl, reason, set, w1c, reason_d;
    logic [DATA_WIDTH-1:0] rd, bp_rd;
`ifdef ADBG_CPU_RSP_HWBP_EN
    logic [DATA_WIDTH-1:0] d_q, bpaddr;
    assign bp_rd = a_q == CPU_ADDR_WIDTH'(3) ? bpaddr : '0;
    assign set = {core_fetch_i & ctrl[2] & (core_pc_i == bpaddr), step, trap};
    always_ff @(posedge cpu_clk_i)
        if (rst_i) bpaddr <= '0;
        else if (wr && a_q == CPU_ADDR_WIDTH'(3)) bpaddr <= d_q;
`else
    logic [RW-1:0] d_q;
    assign bp_rd = '0;
    assign set = {step, trap};
`endif
    assign go = state == IDLE && dbg_stb_i && !rst_i;
    assign in_gpr = dbg_addr_i[CPU_ADDR_WIDTH-1:5] == (CPU_ADDR_WIDTH-5)'(32);
    assign in_npc = dbg_addr_i == CPU_ADDR_WIDTH'(2);
    assign core_halt_o = dbg_stall_i | (|reason);
    // Core strobes fire in the cycle stb is first seen so GPR data is back by the capture edge
    assign core_gpr_re_o = go && core_halt_o && in_gpr && !dbg_we_i;
    assign core_gpr_we_o = go && core_halt_o && in_gpr && dbg_we_i;
    assign core_npc_we_o = go && core_halt_o && in_npc && dbg_we_i;
    assign core_gpr_addr_o = (core_gpr_re_o || core_gpr_we_o) ? dbg_addr_i[4:0] : '0;
    assign core_gpr_wdata_o = core_gpr_we_o ? dbg_data_i : '0;
    assign core_npc_o = core_npc_we_o ? dbg_data_i : '0;
    assign trap = core_trap_i & ctrl[1];
    assign step = core_retire_i & ctrl[0] & !core_halt_o;
    assign wr = state == ACK && we_q;
    assign w1c = (wr && a_q == CPU_ADDR_WIDTH'(1)) ? d_q[RW-1:0] : '0;
    assign reason_d = set | (reason & ~w1c);
    always_comb
        rd = a_q == '0 ? DATA_WIDTH'(ctrl) :
             a_q == CPU_ADDR_WIDTH'(1) ? DATA_WIDTH'(reason) :
             !h_q ? bp_rd :
             a_q == CPU_ADDR_WIDTH'(2) ? core_npc_i :
             a_q[CPU_ADDR_WIDTH-1:5] == (CPU_ADDR_WIDTH-5)'(32) ? core_gpr_rdata_i : bp_rd;
    always_ff @(posedge cpu_clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            a_q <= '0;
            we_q <= 1'b0;
            h_q <= 1'b0;
            cnt <= '0;
            d_q <= '0;
            ctrl <= '0;
            reason <= '0;
            dbg_bp_o <= 1'b0;
            dbg_ack_o <= 1'b0;
            dbg_data_o <= '0;
        end else begin
            reason <= reason_d;
            dbg_bp_o <= |reason_d;
            if (wr && a_q == '0) ctrl <= d_q[RW-1:0];
            case (state)
                IDLE: if (dbg_stb_i) begin
                    a_q <= dbg_addr_i;
                    we_q <= dbg_we_i;
                    d_q <= $bits(d_q)'(dbg_data_i);
                    h_q <= core_halt_o;
                    cnt <= 4'(WAIT_STATES - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == '0) begin
                    dbg_ack_o <= 1'b1;
                    dbg_data_o <= we_q ? '0 : rd;
                    state <= ACK;
                end else cnt <= cnt - 4'd1;
                ACK: begin
                    dbg_ack_o <= 1'b0;
                    dbg_data_o <= '0;
                    state <= DONE;
                end
                DONE: if (!dbg_stb_i) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adbg_cpu_dbg_responder.sv
// tb_adbg_cpu_dbg_responder: directed vectors, expected read data queued per access and popped on each ack
module tb_adbg_cpu_dbg_responder;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0, npc_i = '0, gpr_rdata = '0, rdata;
    logic stb = 1'b0, we = 1'b0, stall = 1'b0, trap = 1'b0, retire = 1'b0;
    logic ack, bp, halt, npc_we, gpr_re, gpr_we;
    logic [31:0] npc_o, gpr_wdata;
    logic [4:0] gpr_addr;
`ifdef ADBG_CPU_RSP_HWBP_EN
    logic [31:0] pc = '0;
    logic fetch = 1'b0;
`endif
    int checks = 0, errors = 0, re_n = 0, we_n = 0, npc_n = 0;
    logic [4:0] last_addr = '0;
    logic [31:0] last_wd = '0, last_npc = '0, e;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    adbg_cpu_dbg_responder dut (
        .cpu_clk_i(clk), .rst_i(rst), .dbg_addr_i(addr), .dbg_data_i(wdata), .dbg_data_o(rdata),
        .dbg_stb_i(stb), .dbg_we_i(we), .dbg_ack_o(ack), .dbg_stall_i(stall), .dbg_bp_o(bp),
        .core_halt_o(halt), .core_trap_i(trap), .core_retire_i(retire), .core_npc_i(npc_i),
        .core_npc_o(npc_o), .core_npc_we_o(npc_we), .core_gpr_addr_o(gpr_addr), .core_gpr_re_o(gpr_re),
        .core_gpr_rdata_i(gpr_rdata), .core_gpr_we_o(gpr_we),
`ifdef ADBG_CPU_RSP_HWBP_EN
        .core_pc_i(pc), .core_fetch_i(fetch),
`endif
        .core_gpr_wdata_o(gpr_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (gpr_re) begin re_n++; last_addr = gpr_addr; end
        if (gpr_we) begin we_n++; last_addr = gpr_addr; last_wd = gpr_wdata; end
        if (npc_we) begin npc_n++; last_npc = npc_o; end
        if (ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack got ack with data %h want no ack", rdata);
            end else begin
                e = exp_q.pop_front();
                chk("ack_data", rdata, e);
            end
        end
    end

    task automatic acc(input logic [15:0] a, input logic w, input logic [31:0] d, input logic [31:0] ex, input int hold = 0);
        int lat;
        @(posedge clk); #1;
        addr = a; we = w; wdata = d; stb = 1'b1;
        exp_q.push_back(ex);
        lat = 0;
        @(negedge clk);
        while (!ack && lat < 20) begin @(negedge clk); lat++; end
        chk("ack_latency", lat, 32'd2);
        if (!ack && exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (hold) @(negedge clk);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic pulse_trap();
        @(posedge clk); #1 trap = 1'b1;
        @(posedge clk); #1 trap = 1'b0;
    endtask

    task automatic pulse_retire();
        @(posedge clk); #1 retire = 1'b1;
        @(posedge clk); #1 retire = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ack_data", {ack, bp, halt, rdata[28:0]}, 32'h0);
        chk("rst_strobes", {npc_we, gpr_re, gpr_we, gpr_addr}, 32'h0);
        chk("rst_npc_wd", npc_o | gpr_wdata, 32'h0);
        acc(16'h0001, 1'b0, 32'h0, 32'h0);
        chk("bp_idle", 32'(bp), 32'h0);
        acc(16'h0000, 1'b1, 32'h2, 32'h0);
        acc(16'h0000, 1'b0, 32'h0, 32'h2);
        pulse_trap();
        @(negedge clk);
        chk("trap_halt", 32'(halt), 32'h1);
        chk("trap_bp", 32'(bp), 32'h1);
        acc(16'h0001, 1'b0, 32'h0, 32'h1);
        acc(16'h0001, 1'b1, 32'h1, 32'h0);
        @(negedge clk);
        chk("w1c_halt", 32'(halt), 32'h0);
        chk("w1c_bp", 32'(bp), 32'h0);
        acc(16'h0001, 1'b0, 32'h0, 32'h0);
        stall = 1'b1;
        gpr_rdata = 32'hDEADBEEF;
        npc_i = 32'h00000ABC;
        @(negedge clk);
        chk("stall_halt", 32'(halt), 32'h1);
        acc(16'h0405, 1'b0, 32'h0, 32'hDEADBEEF);
        chk("gpr_re_count", 32'(re_n), 32'd1);
        chk("gpr_re_addr", 32'(last_addr), 32'd5);
        acc(16'h041F, 1'b1, 32'h12345678, 32'h0);
        chk("gpr_we_count", 32'(we_n), 32'd1);
        chk("gpr_we_addr", 32'(last_addr), 32'd31);
        chk("gpr_wdata", last_wd, 32'h12345678);
        acc(16'h0002, 1'b0, 32'h0, 32'h00000ABC);
        acc(16'h0002, 1'b1, 32'h55, 32'h0);
        chk("npc_we_count", 32'(npc_n), 32'd1);
        chk("npc_wdata", last_npc, 32'h55);
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_halt", 32'(halt), 32'h0);
        acc(16'h0002, 1'b1, 32'h1000, 32'h0);
        chk("npc_unhalted", 32'(npc_n), 32'd1);
        acc(16'h0002, 1'b0, 32'h0, 32'h0);
        acc(16'h0405, 1'b0, 32'h0, 32'h0);
        acc(16'h041F, 1'b1, 32'h0BAD, 32'h0);
        chk("gpr_unhalted", 32'(re_n + we_n), 32'd2);
        acc(16'h0000, 1'b0, 32'h0, 32'h2, 10);
        chk("held_stb_queue", 32'(exp_q.size()), 32'd0);
`ifndef ADBG_CPU_RSP_HWBP_EN
        acc(16'h0003, 1'b0, 32'h0, 32'h0);
`endif
        acc(16'h0100, 1'b1, 32'hFFFF, 32'h0);
        acc(16'h0100, 1'b0, 32'h0, 32'h0);
        acc(16'h0000, 1'b1, 32'h7, 32'h0);
`ifdef ADBG_CPU_RSP_HWBP_EN
        acc(16'h0000, 1'b0, 32'h0, 32'h7);
`else
        acc(16'h0000, 1'b0, 32'h0, 32'h3);
`endif
        pulse_retire();
        @(negedge clk);
        chk("step_halt", 32'(halt), 32'h1);
        acc(16'h0001, 1'b0, 32'h0, 32'h2);
        pulse_retire();
        acc(16'h0001, 1'b0, 32'h0, 32'h2);
        fork
            acc(16'h0001, 1'b1, 32'h3, 32'h0);
            begin
                @(posedge ack); #1 trap = 1'b1;
                @(posedge clk); #1 trap = 1'b0;
            end
        join
        acc(16'h0001, 1'b0, 32'h0, 32'h1);
        acc(16'h0001, 1'b1, 32'h1, 32'h0);
        @(negedge clk);
        chk("release_halt", 32'(halt), 32'h0);
`ifdef ADBG_CPU_RSP_HWBP_EN
        acc(16'h0003, 1'b1, 32'h2000, 32'h0);
        acc(16'h0003, 1'b0, 32'h0, 32'h2000);
        acc(16'h0000, 1'b1, 32'h4, 32'h0);
        @(posedge clk); #1 pc = 32'h1FFC; fetch = 1'b1;
        @(posedge clk); #1 fetch = 1'b0;
        acc(16'h0001, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1 pc = 32'h2000; fetch = 1'b1;
        @(posedge clk); #1 fetch = 1'b0;
        acc(16'h0001, 1'b0, 32'h0, 32'h4);
        chk("hwbp_bp", 32'(bp), 32'h1);
        acc(16'h0001, 1'b1, 32'h4, 32'h0);
`endif
        acc(16'h0000, 1'b1, 32'h2, 32'h0);
        pulse_trap();
        @(negedge clk);
        chk("pre_rst_bp", 32'(bp), 32'h1);
        @(posedge clk); #1;
        addr = 16'h0001; we = 1'b0; stb = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("wait_no_ack", 32'(ack), 32'h0);
        @(negedge clk);
        chk("midrst_outs", {ack, bp, halt, npc_we, gpr_re, gpr_we, gpr_addr}, 32'h0);
        chk("midrst_data", rdata | npc_o | gpr_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; stb = 1'b0;
        repeat (4) @(negedge clk);
        acc(16'h0000, 1'b0, 32'h0, 32'h0);
        acc(16'h0001, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
